// File: rtl/window_buffer_3x3_pkg.sv
// Shared constants and helpers for the 3x3 sliding-window generator.
// The window is stored flat, row-major, oldest line and oldest column first.
package window_buffer_pkg;

    localparam int WIN_SIZE  = 3;
    localparam int WIN_ELEMS = WIN_SIZE * WIN_SIZE;

    // Flat element index of window position (r, c).
    function automatic int win_idx(input int r, input int c);
        return r * WIN_SIZE + c;
    endfunction

endpackage

// File: rtl/window_buffer_3x3_if.sv
// Pixel-stream in / window-stream out bundle for window_buffer_3x3.
// The master modport is the pixel source side. The slave modport is the window generator.
interface window_buffer_3x3_if
    import window_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);

    logic                            px_valid_i;
    logic [DATA_WIDTH-1:0]           px_data_i;
    logic                            px_sof_i;
    logic                            px_eol_i;
    logic                            win_valid_o;
    logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data_o;
    logic                            win_eol_o;
    logic                            err_o;

    modport master (
        output px_valid_i, px_data_i, px_sof_i, px_eol_i,
        input  win_valid_o, win_data_o, win_eol_o, err_o
    );

    modport slave (
        input  px_valid_i, px_data_i, px_sof_i, px_eol_i,
        output win_valid_o, win_data_o, win_eol_o, err_o
    );

endinterface

// File: rtl/window_buffer_3x3_dual_port_ram.sv
// Simple dual-port line RAM with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // NOTE: the storage array is deliberately not reset, so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/window_buffer_3x3.sv
// Streaming 3x3 window generator. Two line RAMs hold the previous two lines, and a 3x3 shift
// register builds the neighbourhood. A window is emitted two cycles after each interior pixel.
module window_buffer_3x3
    import window_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_LINE   = 32,
    localparam int ADDR_WIDTH = $clog2(MAX_LINE)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    window_buffer_3x3_if.slave  win_if
);

    localparam int                    WIN_W    = WIN_ELEMS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(MAX_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] MIN_COL  = ADDR_WIDTH'(2);
    localparam logic [1:0]            ROW_FULL = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic                  drop;
        logic                  eol;
        logic [1:0]            row;
        logic [ADDR_WIDTH-1:0] col;
        logic [DATA_WIDTH-1:0] px;
    } stage1_t;

    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [1:0]            row_q, row_d;
    logic                  drop_q, drop_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] eff_col;
    logic [1:0]            eff_row;
    logic                  px_drop;

    stage1_t               s1_q, s1_d;
    logic                  s1_take;

    logic [DATA_WIDTH-1:0] ram0_rd;
    logic [DATA_WIDTH-1:0] ram1_rd;

    logic [WIN_W-1:0]      shift_q, shift_d;
    logic [WIN_W-1:0]      win_data_q, win_data_d;
    logic                  win_valid_q, win_valid_d;
    logic                  win_eol_q, win_eol_d;

    // A start-of-frame pixel overrides whatever position the counters hold.
    assign eff_row = win_if.px_sof_i ? 2'd0 : row_q;
    assign eff_col = win_if.px_sof_i ? '0 : col_q;
    assign px_drop = drop_q && !win_if.px_sof_i;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        col_d  = col_q;
        row_d  = row_q;
        drop_d = drop_q;
        err_d  = err_q;
        if (win_if.px_valid_i) begin
            col_d  = eff_col;
            row_d  = eff_row;
            drop_d = px_drop;
            if (win_if.px_sof_i) begin
                err_d = 1'b0;
            end
            if (win_if.px_eol_i) begin
                col_d  = '0;
                row_d  = (eff_row == ROW_FULL) ? ROW_FULL : eff_row + 2'd1;
                drop_d = 1'b0;
            end else if (!px_drop) begin
                if (eff_col == LAST_COL) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end else begin
                    col_d = eff_col + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign s1_d = '{
        valid: win_if.px_valid_i,
        drop:  px_drop,
        eol:   win_if.px_eol_i,
        row:   eff_row,
        col:   eff_col,
        px:    win_if.px_data_i
    };

    assign s1_take = s1_q.valid && !s1_q.drop;

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line0 (
        .clk_i     (clk_i),
        .rd_en_i   (win_if.px_valid_i),
        .rd_addr_i (eff_col),
        .rd_data_o (ram0_rd),
        .wr_en_i   (s1_take),
        .wr_addr_i (s1_q.col),
        .wr_data_i (s1_q.px)
    );

    // Line 1 is fed from line 0's read port, so it always lags one line behind.
    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line1 (
        .clk_i     (clk_i),
        .rd_en_i   (win_if.px_valid_i),
        .rd_addr_i (eff_col),
        .rd_data_o (ram1_rd),
        .wr_en_i   (s1_take),
        .wr_addr_i (s1_q.col),
        .wr_data_i (ram0_rd)
    );

    always_comb begin
        shift_d = shift_q;
        if (s1_take) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE - 1; c++) begin
                    shift_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] =
                        shift_q[win_idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            shift_d[win_idx(0, WIN_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = ram1_rd;
            shift_d[win_idx(1, WIN_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = ram0_rd;
            shift_d[win_idx(2, WIN_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = s1_q.px;
        end
    end

    // The output copy only loads on a valid window, so win_data_o holds between pulses.
    assign win_valid_d = s1_take && (s1_q.row == ROW_FULL) && (s1_q.col >= MIN_COL);
    assign win_eol_d   = win_valid_d && s1_q.eol;
    assign win_data_d  = win_valid_d ? shift_d : win_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_q       <= '0;
            row_q       <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            s1_q        <= '0;
            shift_q     <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_eol_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            s1_q        <= s1_d;
            shift_q     <= shift_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            win_eol_q   <= win_eol_d;
        end
    end

    assign win_if.win_valid_o = win_valid_q;
    assign win_if.win_data_o  = win_data_q;
    assign win_if.win_eol_o   = win_eol_q;
    assign win_if.err_o       = err_q;

endmodule
